// File: rtl/ram_sync_pkg.sv
// Shared sizing constants for the C64 main system RAM.
// Modules that instantiate ram_sync pick these up as their default geometry.
package ram_sync_pkg;

    // 64 KiB of byte-wide storage covers the full C64 memory map
    localparam int C64_RAM_AW = 16;
    localparam int C64_RAM_DW = 8;

endpackage : ram_sync_pkg

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with a registered, read-first output.
// This is the main C64 system RAM store. The reset-time fill wrapper drives
// the address, write-enable and data inputs directly, so writes stay live
// while reset is high. Reset only clears the read-data register and leaves
// the memory array untouched.
// The read-data port is called dout because "do" is a reserved word in
// SystemVerilog.
module ram_sync
    import ram_sync_pkg::*;
#(
    parameter int ADDR_WIDTH = C64_RAM_AW,
    parameter int DATA_WIDTH = C64_RAM_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // One clocked process holds both the array and the output register, which lets block RAM be inferred. The read samples the old word, so a write to the same address is read-first.
    always_ff @(posedge clk) begin
        if (enable && we) begin
            mem[a] <= di;
        end
        if (reset) begin
            dout <= '0;
        end else if (enable) begin
            dout <= mem[a];
        end
    end

endmodule : ram_sync

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync.
// Directed scenarios are followed by randomized traffic. Every output is
// compared against a behavioural memory model kept as a plain array.
module tb_ram_sync;
    import ram_sync_pkg::*;

    localparam int AW = C64_RAM_AW;
    localparam int DW = C64_RAM_DW;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
    logic [DW-1:0] dout;

    int compare_count;
    int mismatch_count;

    logic [DW-1:0] ref_mem [0:(2**AW)-1];
    logic [DW-1:0] exp_do;

    ram_sync #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .we    (we),
        .a     (a),
        .di    (di),
        .dout  (dout)
    );

    // Free-running clock with a 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: dout=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, advance the reference model, and check dout after the edge
    task automatic applyStimulus(input string tag, input logic rst, input logic en,
                                 input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        @(negedge clk);
        reset  = rst;
        enable = en;
        we     = wr;
        a      = addr;
        di     = data;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_do = '0;
        end else if (en) begin
            exp_do = ref_mem[addr];
        end
        if (en && wr) begin
            ref_mem[addr] = data;
        end
        checkOutput(tag, dout, exp_do);
    endtask

    // Main sequence: directed scenarios, then random traffic, then the summary
    initial begin
        logic          r_rst;
        logic          r_en;
        logic          r_we;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_di;

        compare_count  = 0;
        mismatch_count = 0;
        for (int i = 0; i < 2**AW; i++) begin
            ref_mem[i] = '0;
        end
        exp_do = '0;
        reset  = 1'b1;
        enable = 1'b0;
        we     = 1'b0;
        a      = '0;
        di     = '0;

        $display("[TB] starting ram_sync bench");

        applyStimulus("reset_state", 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("reset_zero", dout, 8'h00);

        // Write followed by a read of the same word
        applyStimulus("t1_write", 1'b0, 1'b1, 1'b1, 16'h0000, 8'h12);
        applyStimulus("t1_read", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        checkOutput("t1_literal", dout, 8'h12);

        // Disabled write is ignored and dout holds its value
        applyStimulus("t2_disabled", 1'b0, 1'b0, 1'b1, 16'h0010, 8'hAA);
        checkOutput("t2_hold", dout, 8'h12);
        applyStimulus("t2_read", 1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        checkOutput("t2_powerup_zero", dout, 8'h00);

        // Same-address read during write returns the old word
        applyStimulus("t3_preload", 1'b0, 1'b1, 1'b1, 16'h0020, 8'h55);
        applyStimulus("t3_rdw", 1'b0, 1'b1, 1'b1, 16'h0020, 8'h66);
        checkOutput("t3_read_first", dout, 8'h55);
        applyStimulus("t3_reread", 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t3_new_value", dout, 8'h66);

        // A write commits while reset is asserted, and reset clears dout
        applyStimulus("t4_setup", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        checkOutput("t4_do_12", dout, 8'h12);
        applyStimulus("t4_reset_wr", 1'b1, 1'b1, 1'b1, 16'h0004, 8'h07);
        checkOutput("t4_reset_clear", dout, 8'h00);
        applyStimulus("t4_read", 1'b0, 1'b1, 1'b0, 16'h0004, 8'h00);
        checkOutput("t4_write_in_reset", dout, 8'h07);

        // The top address is its own word and does not alias address 0
        applyStimulus("t5_wr_top", 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'hC3);
        applyStimulus("t5_wr_zero", 1'b0, 1'b1, 1'b1, 16'h0000, 8'h3C);
        applyStimulus("t5_rd_top", 1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00);
        checkOutput("t5_top", dout, 8'hC3);
        applyStimulus("t5_rd_zero", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        checkOutput("t5_zero", dout, 8'h3C);

        // Back-to-back reads each appear one cycle after their address
        applyStimulus("t6_rd0", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        checkOutput("t6_first", dout, 8'h3C);
        applyStimulus("t6_rd1", 1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00);
        checkOutput("t6_second", dout, 8'hC3);
        applyStimulus("t6_rd2", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        checkOutput("t6_third", dout, 8'h3C);

        // Random traffic over a small address pool so reads often hit earlier writes
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 19) == 0);
            r_en  = ($urandom_range(0, 4) != 0);
            r_we  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       r_a = 16'hFFFF;
                1:       r_a = 16'h0000;
                default: r_a = AW'($urandom_range(0, 31) * 997);
            endcase
            r_di = DW'($urandom);
            applyStimulus("random", r_rst, r_en, r_we, r_a, r_di);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule : tb_ram_sync
